// File: rtl/data_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_arbiter
// Purpose  : Shares one OBI-style data port (mm_ram) between the core LSU
//            (port C) and the debug-module system-bus master (port S).
//            Requests are forwarded combinationally. A stalled winner is
//            locked until it is granted. S normally wins, but C is forced
//            through after STARVE_LIMIT consecutive lost cycles. An in-order
//            owner FIFO steers each response back to the port that issued
//            it.
// Ports    : clk_i, rst_ni                 clock, async active-low reset
//            c_*   (req/addr/we/be/wdata -> gnt/rvalid/rdata)  core port
//            s_*   (same set)                                  system-bus port
//            mem_* (req/addr/we/be/wdata <- gnt/rvalid/rdata)  memory port
//            err_o                         sticky unexpected-response flag
//            c_gnt_cnt_o, s_gnt_cnt_o      per-port handshake counters
// Options  : DATA_ARB_PERF_EN  when defined, the counters are 16-bit
//            saturating handshake counters; otherwise both read zero.
// Revision : 1.0  initial release
// ============================================================================
module data_bus_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned STARVE_LIMIT    = 8,
  parameter int unsigned ADDR_WIDTH      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // core requester
  input  logic                  c_req_i,
  input  logic [ADDR_WIDTH-1:0] c_addr_i,
  input  logic                  c_we_i,
  input  logic [3:0]            c_be_i,
  input  logic [31:0]           c_wdata_i,
  output logic                  c_gnt_o,
  output logic                  c_rvalid_o,
  output logic [31:0]           c_rdata_o,
  // system-bus requester
  input  logic                  s_req_i,
  input  logic [ADDR_WIDTH-1:0] s_addr_i,
  input  logic                  s_we_i,
  input  logic [3:0]            s_be_i,
  input  logic [31:0]           s_wdata_i,
  output logic                  s_gnt_o,
  output logic                  s_rvalid_o,
  output logic [31:0]           s_rdata_o,
  // memory side
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  // status
  output logic                  err_o,
  output logic [15:0]           c_gnt_cnt_o,
  output logic [15:0]           s_gnt_cnt_o
);

  localparam int unsigned PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [PTR_W-1:0]    PTR_LAST   = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0]    CNT_FULL   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  // ARB: free arbitration each cycle. HOLD: owner_q is locked until granted.
  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic                   owner_q, owner_d;      // 0 = C, 1 = S
  logic [STARVE_W-1:0]    starve_cnt_q, starve_cnt_d;
  logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;    // owner ID per outstanding slot
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   err_q, err_d;

  logic win_s;        // selected requester is S
  logic win_req;      // selected requester is asking
  logic fifo_full;
  logic fifo_empty;
  logic issue_ok;
  logic handshake;
  logic pop;
  logic head_s;

  // --------------------------------------------------------------------------
  // Winner selection
  // --------------------------------------------------------------------------
  always_comb begin
    win_s   = 1'b0;
    win_req = 1'b0;
    if (state_q == ST_HOLD) begin
      win_s   = owner_q;
      win_req = owner_q ? s_req_i : c_req_i;
    end else if (s_req_i && !(c_req_i && (starve_cnt_q == STARVE_MAX))) begin
      win_s   = 1'b1;
      win_req = 1'b1;
    end else begin
      win_s   = 1'b0;
      win_req = c_req_i;
    end
  end

  assign fifo_full  = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);
  // A response arriving this cycle frees a slot, so a full FIFO may still issue.
  assign issue_ok   = !fifo_full || mem_rvalid_i;

  assign mem_req_o   = rst_ni && win_req && issue_ok;
  assign mem_addr_o  = win_s ? s_addr_i  : c_addr_i;
  assign mem_we_o    = win_s ? s_we_i    : c_we_i;
  assign mem_be_o    = win_s ? s_be_i    : c_be_i;
  assign mem_wdata_o = win_s ? s_wdata_i : c_wdata_i;

  assign handshake = mem_req_o && mem_gnt_i;
  assign c_gnt_o   = handshake && !win_s;
  assign s_gnt_o   = handshake &&  win_s;

  // --------------------------------------------------------------------------
  // Response routing
  // --------------------------------------------------------------------------
  assign pop        = rst_ni && mem_rvalid_i && !fifo_empty;
  assign head_s     = fifo_q[rd_ptr_q];
  assign c_rvalid_o = pop && !head_s;
  assign s_rvalid_o = pop &&  head_s;
  assign c_rdata_o  = mem_rdata_i;
  assign s_rdata_o  = mem_rdata_i;
  assign err_o      = err_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    fifo_d       = fifo_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    err_d        = err_q;

    // lock / release
    case (state_q)
      ST_ARB: begin
        if (mem_req_o && !mem_gnt_i) begin
          state_d = ST_HOLD;
          owner_d = win_s;
        end
      end
      ST_HOLD: begin
        if (handshake) begin
          state_d = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase

    // starvation counter
    if (!c_req_i || c_gnt_o) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != STARVE_MAX) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end

    // outstanding FIFO
    if (handshake) begin
      fifo_d[wr_ptr_q] = win_s;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    if (handshake && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!handshake && pop) begin
      count_d = count_q - 1'b1;
    end

    // a response with nothing outstanding is dropped and flagged
    if (mem_rvalid_i && fifo_empty) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_ARB;
      owner_q      <= 1'b0;
      starve_cnt_q <= '0;
      fifo_q       <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      fifo_q       <= fifo_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      err_q        <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Optional per-port handshake counters
  // --------------------------------------------------------------------------
`ifdef DATA_ARB_PERF_EN
  logic [15:0] c_gnt_cnt_q, c_gnt_cnt_d;
  logic [15:0] s_gnt_cnt_q, s_gnt_cnt_d;

  always_comb begin
    c_gnt_cnt_d = c_gnt_cnt_q;
    s_gnt_cnt_d = s_gnt_cnt_q;
    if (c_gnt_o && (c_gnt_cnt_q != 16'hFFFF)) begin
      c_gnt_cnt_d = c_gnt_cnt_q + 16'd1;
    end
    if (s_gnt_o && (s_gnt_cnt_q != 16'hFFFF)) begin
      s_gnt_cnt_d = s_gnt_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      c_gnt_cnt_q <= 16'h0000;
      s_gnt_cnt_q <= 16'h0000;
    end else begin
      c_gnt_cnt_q <= c_gnt_cnt_d;
      s_gnt_cnt_q <= s_gnt_cnt_d;
    end
  end

  assign c_gnt_cnt_o = c_gnt_cnt_q;
  assign s_gnt_cnt_o = s_gnt_cnt_q;
`else
  assign c_gnt_cnt_o = 16'h0000;
  assign s_gnt_cnt_o = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_bus_arbiter
// Purpose  : Directed self-checking bench for data_bus_arbiter. A queue-based
//            reference model is checked every falling edge; directed
//            scenarios add literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_data_bus_arbiter;

  localparam int unsigned MAXO   = 2;
  localparam int unsigned STARVE = 8;
  localparam int unsigned AW     = 32;

  logic          clk;
  logic          rst_ni;
  logic          c_req_i, s_req_i;
  logic [AW-1:0] c_addr_i, s_addr_i;
  logic          c_we_i, s_we_i;
  logic [3:0]    c_be_i, s_be_i;
  logic [31:0]   c_wdata_i, s_wdata_i;
  logic          c_gnt_o, s_gnt_o, c_rvalid_o, s_rvalid_o;
  logic [31:0]   c_rdata_o, s_rdata_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [3:0]    mem_be_o;
  logic [31:0]   mem_wdata_o;
  logic          mem_gnt_i, mem_rvalid_i;
  logic [31:0]   mem_rdata_i;
  logic          err_o;
  logic [15:0]   c_gnt_cnt_o, s_gnt_cnt_o;

  data_bus_arbiter #(
    .MAX_OUTSTANDING(MAXO),
    .STARVE_LIMIT   (STARVE),
    .ADDR_WIDTH     (AW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .c_req_i     (c_req_i),
    .c_addr_i    (c_addr_i),
    .c_we_i      (c_we_i),
    .c_be_i      (c_be_i),
    .c_wdata_i   (c_wdata_i),
    .c_gnt_o     (c_gnt_o),
    .c_rvalid_o  (c_rvalid_o),
    .c_rdata_o   (c_rdata_o),
    .s_req_i     (s_req_i),
    .s_addr_i    (s_addr_i),
    .s_we_i      (s_we_i),
    .s_be_i      (s_be_i),
    .s_wdata_i   (s_wdata_i),
    .s_gnt_o     (s_gnt_o),
    .s_rvalid_o  (s_rvalid_o),
    .s_rdata_o   (s_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_we_o    (mem_we_o),
    .mem_be_o    (mem_be_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i),
    .err_o       (err_o),
    .c_gnt_cnt_o (c_gnt_cnt_o),
    .s_gnt_cnt_o (s_gnt_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // --------------------------------------------------------------------------
  // Reference model: who is owed a response (queue), lock state, how long C
  // has been waiting, error flag and handshake tallies.
  // --------------------------------------------------------------------------
  bit m_q[$];
  bit m_locked;
  bit m_owner;
  int m_starve;
  bit m_err;
  int m_cc, m_sc;

  bit e_ws, e_wreq, e_req, e_cg, e_sg, e_cr, e_sr;
  logic [15:0] e_ccnt, e_scnt;

  always @(negedge clk) begin
    if (!rst_ni) begin
      m_q.delete();
      m_locked = 0; m_owner = 0; m_starve = 0; m_err = 0; m_cc = 0; m_sc = 0;
      chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
      chk("rst_gnt", {30'd0, c_gnt_o, s_gnt_o}, 32'd0);
      chk("rst_rvalid", {30'd0, c_rvalid_o, s_rvalid_o}, 32'd0);
      chk("rst_err", {31'd0, err_o}, 32'd0);
    end else begin
      if (m_locked) begin
        e_ws = m_owner;
        e_wreq = m_owner ? s_req_i : c_req_i;
      end else if (s_req_i && !(c_req_i && m_starve == STARVE)) begin
        e_ws = 1; e_wreq = 1;
      end else begin
        e_ws = 0; e_wreq = c_req_i;
      end
      e_req = e_wreq && ((m_q.size() < MAXO) || mem_rvalid_i);
      e_cg  = e_req && mem_gnt_i && !e_ws;
      e_sg  = e_req && mem_gnt_i &&  e_ws;
      e_cr  = mem_rvalid_i && (m_q.size() > 0) && (m_q[0] == 1'b0);
      e_sr  = mem_rvalid_i && (m_q.size() > 0) && (m_q[0] == 1'b1);
`ifdef DATA_ARB_PERF_EN
      e_ccnt = 16'(m_cc);
      e_scnt = 16'(m_sc);
`else
      e_ccnt = 16'h0000;
      e_scnt = 16'h0000;
`endif
      chk("mdl_mem_req", {31'd0, mem_req_o}, {31'd0, e_req});
      chk("mdl_c_gnt", {31'd0, c_gnt_o}, {31'd0, e_cg});
      chk("mdl_s_gnt", {31'd0, s_gnt_o}, {31'd0, e_sg});
      chk("mdl_c_rvalid", {31'd0, c_rvalid_o}, {31'd0, e_cr});
      chk("mdl_s_rvalid", {31'd0, s_rvalid_o}, {31'd0, e_sr});
      chk("mdl_err", {31'd0, err_o}, {31'd0, m_err});
      chk("mdl_cnt", {c_gnt_cnt_o, s_gnt_cnt_o}, {e_ccnt, e_scnt});
      if (e_req) begin
        chk("mdl_addr", mem_addr_o, e_ws ? s_addr_i : c_addr_i);
        chk("mdl_attr", {mem_we_o, mem_be_o, 27'd0},
            e_ws ? {s_we_i, s_be_i, 27'd0} : {c_we_i, c_be_i, 27'd0});
        chk("mdl_wdata", mem_wdata_o, e_ws ? s_wdata_i : c_wdata_i);
      end
      if (e_cr) chk("mdl_c_rdata", c_rdata_o, mem_rdata_i);
      if (e_sr) chk("mdl_s_rdata", s_rdata_o, mem_rdata_i);

      // advance model state
      if (mem_rvalid_i) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_err = 1;
      end
      if (e_req && mem_gnt_i) begin
        m_q.push_back(e_ws);
        m_locked = 0;
        if (e_ws) m_sc = (m_sc < 65535) ? m_sc + 1 : m_sc;
        else      m_cc = (m_cc < 65535) ? m_cc + 1 : m_cc;
      end else if (e_req) begin
        m_locked = 1;
        m_owner  = e_ws;
      end
      if (!c_req_i || e_cg) m_starve = 0;
      else if (m_starve < STARVE) m_starve++;
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus. Inputs change 1 time unit after a rising edge;
  // literal checks run 1 unit later, well before the falling edge.
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    c_req_i = 0; s_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
  endtask

  initial begin
    rst_ni = 0;
    c_addr_i = 32'h0000_0100; c_we_i = 0; c_be_i = 4'hF; c_wdata_i = 32'h1111_1111;
    s_addr_i = 32'h0000_0200; s_we_i = 1; s_be_i = 4'h3; s_wdata_i = 32'h2222_2222;
    mem_rdata_i = 32'h0;
    c_req_i = 1; s_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1;
    step();
    #1;
    chk("rst_lit_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_lit_gnt", {30'd0, c_gnt_o, s_gnt_o}, 32'd0);
    step();
    idle();
    rst_ni = 1;
    step();

    // 1: C-only read, granted at once, response one cycle later
    c_req_i = 1; mem_gnt_i = 1;
    #1;
    chk("t1_c_gnt", {31'd0, c_gnt_o}, 32'd1);
    chk("t1_addr", mem_addr_o, 32'h0000_0100);
    step();
    idle(); mem_rvalid_i = 1; mem_rdata_i = 32'hDEAD_BEEF;
    #1;
    chk("t1_c_rvalid", {31'd0, c_rvalid_o}, 32'd1);
    chk("t1_c_rdata", c_rdata_o, 32'hDEAD_BEEF);
    chk("t1_s_rvalid", {31'd0, s_rvalid_o}, 32'd0);
    step();
    idle();

    // 2: both request continuously; S wins 8 cycles, then C once
    c_req_i = 1; s_req_i = 1; mem_gnt_i = 1;
    for (int i = 0; i < 18; i++) begin
      if (i > 0) begin
        mem_rvalid_i = 1; mem_rdata_i = 32'(i);
      end
      #1;
      chk("t2_c_gnt", {31'd0, c_gnt_o}, (i % 9 == 8) ? 32'd1 : 32'd0);
      chk("t2_s_gnt", {31'd0, s_gnt_o}, (i % 9 == 8) ? 32'd0 : 32'd1);
      step();
    end
    idle(); mem_rvalid_i = 1;
    step();
    idle();

    // 3: S stalled 3 cycles; C arrives meanwhile and must wait
    s_req_i = 1; s_addr_i = 32'h0000_0200;
    #1;
    chk("t3_addr0", mem_addr_o, 32'h0000_0200);
    step();
    c_req_i = 1; c_addr_i = 32'h0000_0300;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t3_hold_addr", mem_addr_o, 32'h0000_0200);
      chk("t3_hold_cgnt", {31'd0, c_gnt_o}, 32'd0);
      step();
    end
    mem_gnt_i = 1;
    #1;
    chk("t3_s_gnt", {31'd0, s_gnt_o}, 32'd1);
    step();
    s_req_i = 0;
    #1;
    chk("t3_c_gnt", {31'd0, c_gnt_o}, 32'd1);
    chk("t3_c_addr", mem_addr_o, 32'h0000_0300);
    step();
    idle(); mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0055;
    #1;
    chk("t3_s_rvalid", {30'd0, c_rvalid_o, s_rvalid_o}, 32'd1);
    step();
    #1;
    chk("t3_c_rvalid", {30'd0, c_rvalid_o, s_rvalid_o}, 32'd2);
    step();
    idle();

    // 4: FIFO full blocks issue unless a response frees a slot that cycle
    c_req_i = 1; c_addr_i = 32'h0000_0010; mem_gnt_i = 1;
    step();
    c_req_i = 0; s_req_i = 1;
    step();
    s_req_i = 0; c_req_i = 1; c_addr_i = 32'h0000_0014;
    #1;
    chk("t4_full_req", {31'd0, mem_req_o}, 32'd0);
    chk("t4_full_gnt", {31'd0, c_gnt_o}, 32'd0);
    step();
    mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0A0A;
    #1;
    chk("t4_issue_req", {31'd0, mem_req_o}, 32'd1);
    chk("t4_issue_gnt", {31'd0, c_gnt_o}, 32'd1);
    chk("t4_issue_rv", {30'd0, c_rvalid_o, s_rvalid_o}, 32'd2);
    step();
    c_req_i = 0; mem_gnt_i = 0;
    #1;
    chk("t4_drain_s", {30'd0, c_rvalid_o, s_rvalid_o}, 32'd1);
    step();
    #1;
    chk("t4_drain_c", {30'd0, c_rvalid_o, s_rvalid_o}, 32'd2);
    step();
    idle();

    // 5: C,S,C grants with responses 2..4 cycles later, then a spurious one
    c_req_i = 1; mem_gnt_i = 1;
    step();
    c_req_i = 0; s_req_i = 1;
    step();
    s_req_i = 0; c_req_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h0000_00C1;
    #1;
    chk("t5_c_gnt3", {31'd0, c_gnt_o}, 32'd1);
    chk("t5_rv1", {30'd0, c_rvalid_o, s_rvalid_o}, 32'd2);
    step();
    idle();
    step();
    mem_rvalid_i = 1; mem_rdata_i = 32'h0000_00B2;
    #1;
    chk("t5_rv2", {30'd0, c_rvalid_o, s_rvalid_o}, 32'd1);
    chk("t5_s_rdata", s_rdata_o, 32'h0000_00B2);
    step();
    idle();
    step();
    mem_rvalid_i = 1; mem_rdata_i = 32'h0000_00C3;
    #1;
    chk("t5_rv3", {30'd0, c_rvalid_o, s_rvalid_o}, 32'd2);
    step();
    #1;
    chk("t5_spurious_rv", {30'd0, c_rvalid_o, s_rvalid_o}, 32'd0);
    step();
    idle();
    #1;
    chk("t5_err_set", {31'd0, err_o}, 32'd1);
    step();
    step();
    #1;
    chk("t5_err_held", {31'd0, err_o}, 32'd1);
    rst_ni = 0;
    #1;
    chk("t5_err_clr", {31'd0, err_o}, 32'd0);
    step();
    rst_ni = 1;
    step();

    // 6: 5 C and 3 S handshakes
    for (int k = 0; k < 8; k++) begin
      if (k < 5) c_req_i = 1; else s_req_i = 1;
      mem_gnt_i = 1;
      step();
      idle(); mem_rvalid_i = 1;
      step();
      idle();
    end
    #1;
`ifdef DATA_ARB_PERF_EN
    chk("t6_c_cnt", {16'd0, c_gnt_cnt_o}, 32'd5);
    chk("t6_s_cnt", {16'd0, s_gnt_cnt_o}, 32'd3);
`else
    chk("t6_c_cnt", {16'd0, c_gnt_cnt_o}, 32'd0);
    chk("t6_s_cnt", {16'd0, s_gnt_cnt_o}, 32'd0);
`endif
    step();

    // reset with a transaction in flight: its late response is unexpected
    c_req_i = 1; mem_gnt_i = 1;
    step();
    idle();
    rst_ni = 0;
    step();
    rst_ni = 1;
    step();
    mem_rvalid_i = 1;
    #1;
    chk("t7_flushed_rv", {30'd0, c_rvalid_o, s_rvalid_o}, 32'd0);
    step();
    idle();
    #1;
    chk("t7_err", {31'd0, err_o}, 32'd1);
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
